// File: rtl/parking_gate_arbiter.sv
// parking_gate_arbiter
//   Controller for the single-lane barrier shared by the entry and exit
//   sensor paths. It grants the lane to one direction at a time, refuses
//   entry when the lot is full, holds the barrier open until the matching
//   pass pulse arrives or the open timer expires, then keeps the barrier
//   closed for a clearance period. It owns the authoritative occupancy count.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   req_in     level, car waiting at the entry sensor
//   req_out    level, car waiting at the exit sensor
//   pass_in    1-cycle pulse, car completed entry
//   pass_out   1-cycle pulse, car completed exit
//   gate_open  barrier raised
//   grant_in   lane granted to entry
//   grant_out  lane granted to exit
//   count      cars currently inside
//   full       count == CAPACITY
//   empty      count == 0
//   timeout    1-cycle pulse, grant expired without a pass
//   violation  1-cycle pulse, pass pulse outside the matching grant
//
// state     | meaning
// ----------+--------------------------------------------------------
// IDLE      | barrier closed, arbitrating eligible requests
// GRANT_IN  | barrier open for entry, waiting for pass_in or timeout
// GRANT_OUT | barrier open for exit, waiting for pass_out or timeout
// HOLD      | barrier closed for the clearance time, requests ignored

module parking_gate_arbiter #(
  parameter int CAPACITY    = 7,
  parameter int CNT_W       = 3,
  parameter int OPEN_CYCLES = 24000000,
  parameter int HOLD_CYCLES = 6000000,
  parameter int TMR_W       = 25
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_in,
  input  logic             req_out,
  input  logic             pass_in,
  input  logic             pass_out,
  output logic             gate_open,
  output logic             grant_in,
  output logic             grant_out,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             timeout,
  output logic             violation
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT_IN,
    S_GRANT_OUT,
    S_HOLD
  } state_t;

  // The timer counts down from (N-1) to 0, so the terminal compare is
  // against zero and a phase lasts exactly N cycles.
  localparam logic [TMR_W-1:0] OPEN_LOAD = TMR_W'(OPEN_CYCLES - 1);
  localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CAP       = CNT_W'(CAPACITY);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               last_in_q, last_in_d;   // 1: entry was served last
  logic               timeout_q, timeout_d;
  logic               violation_q, violation_d;
  logic               gate_q, grant_in_q, grant_out_q;

  logic               full_w, empty_w;
  logic               elig_in, elig_out;
  logic               inc, dec;

  assign full_w   = (count_q == CAP);
  assign empty_w  = (count_q == '0);
  assign elig_in  = req_in && !full_w;
  assign elig_out = req_out && !empty_w;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    timer_d     = timer_q;
    last_in_d   = last_in_q;
    timeout_d   = 1'b0;
    violation_d = 1'b0;
    inc         = 1'b0;
    dec         = 1'b0;

    case (state_q)
      S_IDLE: begin
        violation_d = pass_in | pass_out;
        // On a tie the direction not served last wins.
        if (elig_in && (!elig_out || !last_in_q)) begin
          state_d   = S_GRANT_IN;
          timer_d   = OPEN_LOAD;
          last_in_d = 1'b1;
        end else if (elig_out) begin
          state_d   = S_GRANT_OUT;
          timer_d   = OPEN_LOAD;
          last_in_d = 1'b0;
        end
      end

      S_GRANT_IN: begin
        violation_d = pass_out;
        // A pass on the final open cycle wins over the timeout.
        if (pass_in) begin
          inc     = 1'b1;
          state_d = S_HOLD;
          timer_d = HOLD_LOAD;
        end else if (timer_q == '0) begin
          timeout_d = 1'b1;
          state_d   = S_HOLD;
          timer_d   = HOLD_LOAD;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end

      S_GRANT_OUT: begin
        violation_d = pass_in;
        if (pass_out) begin
          dec     = 1'b1;
          state_d = S_HOLD;
          timer_d = HOLD_LOAD;
        end else if (timer_q == '0) begin
          timeout_d = 1'b1;
          state_d   = S_HOLD;
          timer_d   = HOLD_LOAD;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end

      S_HOLD: begin
        violation_d = pass_in | pass_out;
        if (timer_q == '0) begin
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (inc) count_d = count_q + 1'b1;
    if (dec) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      timer_q     <= '0;
      last_in_q   <= 1'b0;
      timeout_q   <= 1'b0;
      violation_q <= 1'b0;
      gate_q      <= 1'b0;
      grant_in_q  <= 1'b0;
      grant_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      timer_q     <= timer_d;
      last_in_q   <= last_in_d;
      timeout_q   <= timeout_d;
      violation_q <= violation_d;
      grant_in_q  <= (state_d == S_GRANT_IN);
      grant_out_q <= (state_d == S_GRANT_OUT);
      gate_q      <= (state_d == S_GRANT_IN) || (state_d == S_GRANT_OUT);
    end
  end

  // Arbitration must make these impossible; a hit means the eligibility
  // gating is broken.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(inc && full_w));
      assert (!(dec && empty_w));
    end
  end

  assign gate_open = gate_q;
  assign grant_in  = grant_in_q;
  assign grant_out = grant_out_q;
  assign count     = count_q;
  assign full      = full_w;
  assign empty     = empty_w;
  assign timeout   = timeout_q;
  assign violation = violation_q;

endmodule

// File: tb/tb_parking_gate_arbiter.sv
module tb_parking_gate_arbiter;

  localparam int CAP = 7;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req_in = 1'b0, req_out = 1'b0, pass_in = 1'b0, pass_out = 1'b0;
  logic       gate_open, grant_in, grant_out, full, empty, timeout, violation;
  logic [2:0] count;

  int checks   = 0;
  int failures = 0;

  parking_gate_arbiter #(
    .CAPACITY   (CAP),
    .CNT_W      (3),
    .OPEN_CYCLES(10),
    .HOLD_CYCLES(4),
    .TMR_W      (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_in   (req_in),
    .req_out  (req_out),
    .pass_in  (pass_in),
    .pass_out (pass_out),
    .gate_open(gate_open),
    .grant_in (grant_in),
    .grant_out(grant_out),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .timeout  (timeout),
    .violation(violation)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    bit    r, ri, ro, pi, po;
    bit    eg, egi, ego;
    int    ec;
    bit    eto, evio;
  } vec_t;

  vec_t vec[17];

  // Drive at the falling edge, check 1 time unit after the next rising edge.
  task automatic apply(input string name, input bit r, input bit ri, input bit ro,
                       input bit pi, input bit po, input bit eg, input bit egi,
                       input bit ego, input int ec, input bit eto, input bit evio);
    logic [9:0] got, exp;
    @(negedge clk);
    rst = r; req_in = ri; req_out = ro; pass_in = pi; pass_out = po;
    @(posedge clk);
    #1;
    got = {gate_open, grant_in, grant_out, count, full, empty, timeout, violation};
    exp = {eg, egi, ego, 3'(ec), (ec == CAP), (ec == 0), eto, evio};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got gate=%0b gi=%0b go=%0b cnt=%0d full=%0b empty=%0b to=%0b vio=%0b, want gate=%0b gi=%0b go=%0b cnt=%0d full=%0b empty=%0b to=%0b vio=%0b",
               name, gate_open, grant_in, grant_out, count, full, empty, timeout, violation,
               exp[9], exp[8], exp[7], exp[6:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  // Grant, matching pass with requests still held, then four HOLD cycles.
  task automatic grant_pass(input bit ri, input bit ro, input bit exp_in, input int cnt);
    int nc;
    nc = exp_in ? cnt + 1 : cnt - 1;
    apply("gp_grant", 0, ri, ro, 0, 0, 1, exp_in, !exp_in, cnt, 0, 0);
    apply("gp_pass", 0, ri, ro, exp_in, !exp_in, 0, 0, 0, nc, 0, 0);
    repeat (4) apply("gp_hold", 0, ri, ro, 0, 0, 0, 0, 0, nc, 0, 0);
  endtask

  initial begin
    //            name          r ri ro pi po  g gi go cnt to vio
    vec[0]  = '{"reset",        1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vec[1]  = '{"grant_in",     0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0};
    vec[2]  = '{"pass_in",      0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0};
    vec[3]  = '{"hold1",        0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    vec[4]  = '{"hold_req2",    0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    vec[5]  = '{"hold_req3",    0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    vec[6]  = '{"hold_end",     0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    vec[7]  = '{"regrant_in",   0, 1, 0, 0, 0, 1, 1, 0, 1, 0, 0};
    vec[8]  = '{"vio_gin",      0, 0, 0, 0, 1, 1, 1, 0, 1, 0, 1};
    vec[9]  = '{"both_pass",    0, 0, 0, 1, 1, 0, 0, 0, 2, 0, 1};
    vec[10] = '{"vio_hold",     0, 0, 0, 0, 1, 0, 0, 0, 2, 0, 1};
    vec[11] = '{"hold2",        0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0};
    vec[12] = '{"hold3",        0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0};
    vec[13] = '{"hold_end2",    0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0};
    vec[14] = '{"vio_idle",     0, 0, 0, 0, 1, 0, 0, 0, 2, 0, 1};
    vec[15] = '{"tie_out",      0, 1, 1, 0, 0, 1, 0, 1, 2, 0, 0};
    vec[16] = '{"pass_out",     0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0};

    for (int i = 0; i < 17; i++)
      apply(vec[i].name, vec[i].r, vec[i].ri, vec[i].ro, vec[i].pi, vec[i].po,
            vec[i].eg, vec[i].egi, vec[i].ego, vec[i].ec, vec[i].eto, vec[i].evio);

    repeat (4) apply("hold_a", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);

    // Timeout: open for exactly 10 cycles, then pulse and close.
    apply("to_grant", 0, 0, 1, 0, 0, 1, 0, 1, 1, 0, 0);
    repeat (9) apply("to_open", 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0);
    apply("to_pulse", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    repeat (4) apply("to_hold", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);

    // Pass on the final open cycle counts as a pass, no timeout.
    apply("last_grant", 0, 1, 0, 0, 0, 1, 1, 0, 1, 0, 0);
    repeat (9) apply("last_open", 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0);
    apply("last_pass", 0, 0, 0, 1, 0, 0, 0, 0, 2, 0, 0);
    repeat (4) apply("last_hold", 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0);

    // Up to 4, one exit to 3 (exit served last), then alternating ties.
    grant_pass(1, 0, 1, 2);
    grant_pass(1, 0, 1, 3);
    grant_pass(0, 1, 0, 4);
    grant_pass(1, 1, 1, 3);
    grant_pass(1, 1, 0, 4);
    grant_pass(1, 1, 1, 3);
    grant_pass(1, 0, 1, 4);

    // Reset in the middle of an exit grant with 5 cars inside.
    apply("go_grant5", 0, 0, 1, 0, 0, 1, 0, 1, 5, 0, 0);
    apply("rst_mid", 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    apply("post_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) apply("empty_no_exit", 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);

    for (int k = 0; k < CAP; k++) grant_pass(1, 0, 1, k);
    repeat (5) apply("full_refuse", 0, 1, 0, 0, 0, 0, 0, 0, 7, 0, 0);
    grant_pass(1, 1, 0, 7);
    grant_pass(1, 1, 1, 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
